// File: rtl/iter_shifter.sv
// Iterative 16-bit shifter/rotator: one bit per cycle, with optional bit reversal
// of the operand at load and of the final value at completion.
module iter_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [2:0]  alu_op,
  input  logic [3:0]  shamt,
  input  logic        flip_1,
  input  logic        flip_2,
  output logic [15:0] result,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_ROL = 2'd0;
  localparam logic [1:0] OP_SLL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;
  localparam logic [1:0] OP_SRL = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  work_q, work_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    op_q, op_d;
  logic          flip2_q, flip2_d;
  logic [W-1:0]  result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) begin
      r[i] = x[int'(W) - 1 - i];
    end
    return r;
  endfunction

  // Next-state and datapath; busy/done are registered from the next state.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    op_d     = op_q;
    flip2_d  = flip2_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = flip_1 ? bitrev(data_in) : data_in;
          count_d = alu_op[2] ? '0 : shamt;
          op_d    = alu_op[1:0];
          flip2_d = flip_2;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (count_q != '0) begin
          case (op_q)
            OP_ROL:  work_d = {work_q[W-2:0], work_q[W-1]};
            OP_SLL:  work_d = {work_q[W-2:0], 1'b0};
            OP_SRA:  work_d = {work_q[W-1], work_q[W-1:1]};
            OP_SRL:  work_d = {1'b0, work_q[W-1:1]};
            default: work_d = work_q;
          endcase
          count_d = count_q - CW'(1);
        end else begin
          result_d = flip2_q ? bitrev(work_q) : work_q;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= OP_ROL;
      flip2_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      op_q     <= op_d;
      flip2_q  <= flip2_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: each accepted start queues its expected
// result and completion cycle; the monitor checks them when done pulses.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] data_in;
  logic [2:0]  alu_op;
  logic [3:0]  shamt;
  logic        flip_1;
  logic        flip_2;
  logic [15:0] result;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic [15:0] last_res   = 16'h0000;

  iter_shifter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .alu_op(alu_op), .shamt(shamt), .flip_1(flip_1), .flip_2(flip_2),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] x);
    return {<<{x}};
  endfunction

  // Independent reference using whole-word shift operators.
  function automatic logic [15:0] ref_op(input logic [15:0] d, input logic [2:0] op,
                                         input logic [3:0] sh, input logic f1, input logic f2);
    logic [15:0] x;
    int n;
    x = f1 ? rev16(d) : d;
    n = int'(sh);
    if (!op[2]) begin
      case (op[1:0])
        2'd0: x = (n == 0) ? x : 16'((x << n) | (x >> (16 - n)));
        2'd1: x = 16'(x << n);
        2'd2: x = 16'($signed(x) >>> n);
        default: x = 16'(x >> n);
      endcase
    end
    return f2 ? rev16(x) : x;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      compared++;
      assert (sb.size() > 0) else begin
        mismatched++;
        $error("FAIL unexpected_done: observed done at cycle %0d expected none", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check16("result", result, e.res);
        check32("done_cycle", cyc, e.cyc);
        last_res = e.res;
      end
    end
  end

  // Called at a negedge while idle: drive one start, queue expectation, scramble inputs.
  task automatic do_start(input logic [15:0] d, input logic [2:0] op, input logic [3:0] sh,
                          input logic f1, input logic f2, input logic [15:0] exp_res);
    exp_t e;
    data_in = d; alu_op = op; shamt = sh; flip_1 = f1; flip_2 = f2;
    start = 1'b1;
    e.res = exp_res;
    e.cyc = cyc + (op[2] ? 0 : int'(sh)) + 2;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'($urandom);
    alu_op  = 3'($urandom);
    shamt   = 4'($urandom);
    flip_1  = 1'($urandom);
    flip_2  = 1'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check32("timeout", int'(n < budget), 1);
  endtask

  initial begin
    exp_t e;
    logic [15:0] d;
    logic [2:0]  op;
    logic [3:0]  sh;
    logic        f1, f2;
    int          c;

    rst_n = 1'b0; start = 1'b1; data_in = 16'hFFFF; alu_op = 3'd0;
    shamt = 4'd3; flip_1 = 1'b0; flip_2 = 1'b0;
    repeat (3) @(negedge clk);
    check16("rst_result", result, 16'h0000);
    check16("rst_busy", 16'(busy), 16'h0000);
    check16("rst_done", 16'(done), 16'h0000);

    // First cycle after reset release: SLL 0x0001 by 4.
    rst_n = 1'b1;
    do_start(16'h0001, 3'b001, 4'd4, 1'b0, 1'b0, 16'h0010);
    check16("busy_inflight", 16'(busy), 16'h0001);
    wait_idle(40);
    repeat (2) @(negedge clk);
    check16("result_hold", result, last_res);
    check16("done_low_idle", 16'(done), 16'h0000);

    do_start(16'h8000, 3'b010, 4'd15, 1'b0, 1'b0, 16'hFFFF);
    wait_idle(40);
    do_start(16'h8000, 3'b011, 4'd15, 1'b0, 1'b0, 16'h0001);
    wait_idle(40);
    do_start(16'h0001, 3'b000, 4'd1, 1'b1, 1'b1, 16'h8000);
    wait_idle(40);
    do_start(16'h8001, 3'b000, 4'd1, 1'b0, 1'b0, 16'h0003);
    wait_idle(40);
    do_start(16'hABCD, 3'b000, 4'd0, 1'b0, 1'b0, 16'hABCD);
    wait_idle(40);
    do_start(16'h1234, 3'b100, 4'd7, 1'b0, 1'b0, 16'h1234);
    wait_idle(40);
    do_start(16'h00F0, 3'b001, 4'd3, 1'b1, 1'b0, 16'h7800);
    wait_idle(40);

    // Busy collision: second start during SHIFT is ignored.
    c = cyc;
    data_in = 16'h0001; alu_op = 3'b001; shamt = 4'd8; flip_1 = 1'b0; flip_2 = 1'b0;
    start = 1'b1;
    e.res = 16'h0100; e.cyc = c + 10; sb.push_back(e);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    data_in = 16'hFFFF; alu_op = 3'b011; shamt = 4'd2; start = 1'b1;
    check16("busy_collision", 16'(busy), 16'h0001);
    @(negedge clk); start = 1'b0;
    wait_idle(40);
    repeat (4) @(negedge clk);

    // start held high: re-accepted the cycle after done (period shamt+3).
    c = cyc;
    data_in = 16'h0003; alu_op = 3'b000; shamt = 4'd2; flip_1 = 1'b0; flip_2 = 1'b0;
    start = 1'b1;
    e.res = 16'h000C; e.cyc = c + 4; sb.push_back(e);
    e.res = 16'h000C; e.cyc = c + 9; sb.push_back(e);
    repeat (6) @(negedge clk);
    start = 1'b0;
    wait_idle(40);

    // Randomised operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      d = 16'($urandom); op = 3'($urandom); sh = 4'($urandom);
      f1 = 1'($urandom); f2 = 1'($urandom);
      do_start(d, op, sh, f1, f2, ref_op(d, op, sh, f1, f2));
      wait_idle(40);
    end

    // Reset mid-operation abandons it with no done pulse.
    data_in = 16'h0001; alu_op = 3'b001; shamt = 4'd10; flip_1 = 1'b0; flip_2 = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check16("midrst_busy", 16'(busy), 16'h0000);
    check16("midrst_done", 16'(done), 16'h0000);
    check16("midrst_result", result, 16'h0000);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check16("postrst_busy", 16'(busy), 16'h0000);
    check16("postrst_result", result, 16'h0000);
    check32("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request to begin an operation; accepted only when busy=0.
REQ-005 data_in  input  16  operand to be shifted/rotated.
REQ-006 alu_op  input  3  operation: 000 ROL, 001 SLL, 010 SRA, 011 SRL, 1xx pass-through.
REQ-007 shamt  input  4  shift/rotate amount, 0-15.
REQ-008 flip_1  input  1  bit-reverse operand at load.
REQ-009 flip_2  input  1  bit-reverse final value at completion.
REQ-010 result  output  16  registered result; holds value until next completion.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  single-cycle completion pulse; result valid in same cycle.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT, DONE, with busy = (state != IDLE) and done = (state == DONE).
REQ-014 In IDLE with start=1, the block SHALL latch work = flip_1 ? bitrev(data_in) : data_in, count = shamt (forced to 0 when alu_op[2]=1), op = alu_op[1:0], flip_2, and move to SHIFT.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE with all registers unchanged.
REQ-016 In SHIFT with count!=0, the block SHALL shift work by exactly one bit per cycle per latched op and decrement count by 1.
REQ-017 One-bit steps: ROL {w[14:0],w[15]}; SLL {w[14:0],0}; SRA {w[15],w[15:1]}; SRL {0,w[15:1]}.
REQ-018 In SHIFT with count==0, the block SHALL load result = latched flip_2 ? bitrev(work) : work and move to DONE.
REQ-019 From DONE, the block SHALL return to IDLE unconditionally on the next edge.
REQ-020 If start is accepted in cycle T, done SHALL be high in cycle T+shamt+2 (T+2 for shamt=0 or pass-through).
REQ-021 start while busy=1 (SHIFT or DONE) SHALL be ignored, with no effect on the in-flight operation.
REQ-022 data_in, alu_op, shamt, flip_1, flip_2 SHALL be sampled only on the accepting edge; later changes SHALL not affect the operation.
REQ-023 ROR SHALL be obtained as alu_op=000 with flip_1=flip_2=1, giving a right-rotate by shamt.
REQ-024 result SHALL change only on the SHIFT->DONE transition or reset.
REQ-025 A new start SHALL be accepted no earlier than the cycle after done (back-to-back throughput shamt+3 cycles).

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, result=0x0000, work=0, count=0, so busy=0 and done=0 the following cycle.
REQ-027 Reset SHALL take priority over start and over any in-flight operation, abandoning it with no done pulse.
REQ-028 After rst_n returns to 1, a start in the first cycle SHALL be accepted normally.

Verification
REQ-029 SLL: data_in=0x0001, shamt=4, start at T -> done at T+6, result=0x0010.
REQ-030 SRA/SRL: data_in=0x8000, shamt=15 -> SRA result=0xFFFF, SRL result=0x0001, done at T+17.
REQ-031 ROR: data_in=0x0001, alu_op=000, flip_1=flip_2=1, shamt=1 -> result=0x8000; ROL 0x8001 shamt=1 -> 0x0003.
REQ-032 Zero/pass-through: ROL shamt=0 data_in=0xABCD -> 0xABCD at T+2; alu_op=100 shamt=7 data_in=0x1234 -> 0x1234 at T+2.
REQ-033 Busy collision: start SLL 0x0001 shamt=8, re-assert start with SRL 0xFFFF at T+3 -> single done at T+10, result=0x0100.
REQ-034 Reset mid-op: start shamt=10, rst_n=0 at T+4 -> busy=0, done never pulses, result=0x0000.
